// File: rtl/param_sram_model_if.sv
//------------------------------------------------------------------------------
// Module : param_sram_model_if
// Brief  : Strobe, address and status bundle of the parametrised SRAM model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface param_sram_model_if #(
  parameter int ADDR_W = 16
);
  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              rd_valid;
  logic [7:0]        err_cnt;

  modport master (
    output oe, we, addr,
    input  busy, rd_valid, err_cnt
  );

  modport slave (
    input  oe, we, addr,
    output busy, rd_valid, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/param_sram_model.sv
//------------------------------------------------------------------------------
// Module : param_sram_model
// Brief  : Clock-synchronous SRAM model, active-low strobes, shared data bus,
//          post-reset clear sequence and pipelined read latency RD_LAT (1..4).
//          Optional illegal-access counter: PARAM_SRAM_MODEL_ERRCNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_sram_model #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  param_sram_model_if.slave  bus,
  inout  wire [DATA_W-1:0]   data_io
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];

  logic              w_busy;
  logic              w_wr;
  logic              w_rd;
  logic              w_clr_last;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_drive;

  assign w_busy     = (r_state == ST_CLEAR);
  assign w_wr       = !w_busy && !bus.we;
  assign w_rd       = !w_busy && !bus.oe && bus.we;
  assign w_clr_last = (r_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if (w_clr_last) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // The clear sequence and host writes share the single write port.
  assign w_mem_we    = w_busy || w_wr;
  assign w_mem_addr  = w_busy ? r_ptr : bus.addr;
  assign w_mem_wdata = w_busy ? '0 : data_io;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Data is captured at issue time, then shifted so one read can issue per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_dat[0] <= r_mem[bus.addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.rd_valid = r_vld[RD_LAT-1];

  // Drive only while the master still holds oe low, avoiding bus contention.
  assign w_drive = r_vld[RD_LAT-1] && !bus.oe;
  assign data_io = w_drive ? r_dat[RD_LAT-1] : {DATA_W{1'bz}};

`ifdef PARAM_SRAM_MODEL_ERRCNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_evt;

  assign w_err_evt = (w_busy && (!bus.oe || !bus.we)) || (!bus.oe && !bus.we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'h00;
`endif

endmodule

`default_nettype wire
